// File: rtl/cdc_src_handshake_if.sv
// Signal bundle between the source-side CDC handshake block and its neighbours:
// the local word interface plus the request/data/acknowledge crossing bus.
interface cdc_src_handshake_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  src_valid;
  logic                  src_ready;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  xfer_req;
  logic [DATA_WIDTH-1:0] xfer_data;
  logic                  xfer_ack_async;
  logic                  src_done;
  logic                  err_clear;
  logic                  timeout_err;

  modport master (
    input  src_valid, src_data, xfer_ack_async, err_clear,
    output src_ready, xfer_req, xfer_data, src_done, timeout_err
  );

  modport slave (
    output src_valid, src_data, xfer_ack_async, err_clear,
    input  src_ready, xfer_req, xfer_data, src_done, timeout_err
  );
endinterface

// File: rtl/cdc_src_handshake.sv
// Launching half of a 4-phase multi-bit CDC handshake: holds a word on the
// crossing bus, raises a request level and waits for the synchronised ack.
module cdc_src_handshake #(
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                src_clk,
  input  logic                src_reset,
  cdc_src_handshake_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] flush_q;
  logic                   req_q, req_d;
  logic                   ready_q, ready_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   ack_s, ack_s_next, flushed_next;
  logic                   accept, timeout_hit;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign ack_s        = sync_q[SYNC_STAGES-1];
  assign ack_s_next   = sync_q[SYNC_STAGES-2];
  // Ready stays low until the synchroniser holds an ack sampled after reset,
  // so a stale high ack at reset release can never launch a transfer.
  assign flushed_next = flush_q[SYNC_STAGES-2];
  assign accept       = (state_q == IDLE) && ready_q && bus.src_valid;
  assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (state_q != IDLE) &&
                        (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = REQ;
          req_d   = 1'b1;
          data_d  = bus.src_data;
        end
      end
      REQ: begin
        if (ack_s) begin
          state_d = RELEASE;
          req_d   = 1'b0;
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase

    ready_d = (state_d == IDLE) && !ack_s_next && flushed_next;

    if ((state_d != state_q) || (state_q == IDLE)) cnt_d = '0;
    else                                           cnt_d = sat_inc(cnt_q);

    // A timeout landing on the same edge as a clear must stay visible.
    if (timeout_hit)        err_d = 1'b1;
    else if (bus.err_clear) err_d = 1'b0;
    else                    err_d = err_q;
  end

  always_ff @(posedge src_clk or posedge src_reset) begin
    if (src_reset) begin
      state_q <= IDLE;
      sync_q  <= '0;
      flush_q <= '0;
      req_q   <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.xfer_ack_async};
      flush_q <= {flush_q[SYNC_STAGES-2:0], 1'b1};
      req_q   <= req_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.src_ready   = ready_q;
  assign bus.xfer_req    = req_q;
  assign bus.xfer_data   = data_q;
  assign bus.src_done    = done_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_cdc_src_handshake.sv
// Bench for cdc_src_handshake: the bench plays the destination domain and
// predicts every edge from handshake timing arithmetic and a word queue.
module tb_cdc_src_handshake;
  localparam int DW   = 8;
  localparam int SYNC = 2;
  localparam int TO   = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  logic [DW-1:0] exp_q[$];

  cdc_src_handshake_if #(.DATA_WIDTH(DW)) bus();

  cdc_src_handshake #(
    .DATA_WIDTH(DW), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(16)
  ) dut (
    .src_clk(clk),
    .src_reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic ack_level);
    rst = 1'b1;
    bus.xfer_ack_async = ack_level;
    bus.src_valid = 1'b0;
    bus.err_clear = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Word under test leaves exp_q at the accept edge (edge 0). Ack rises before
  // edge d1+1, so req falls at F = d1+1+SYNC; ack drops d2 cycles after that,
  // so the done pulse (and ready) appears at D = F+d2+1+SYNC.
  task automatic run_transfer(input string tag, input int d1, input int d2,
                              input logic hold_v, input logic [DW-1:0] hold_d,
                              input logic chain);
    logic [DW-1:0] w;
    logic e_req, e_done, e_rdy;
    int f_e, d_e;
    w   = exp_q.pop_front();
    f_e = d1 + 1 + SYNC;
    d_e = f_e + d2 + 1 + SYNC;
    for (int n = 0; n <= d_e; n++) begin
      tick();
      e_req  = (n < f_e);
      e_done = (n == d_e);
      e_rdy  = (n == d_e);
      checks++;
      if (bus.xfer_req !== e_req) begin
        failures++;
        $display("FAIL %s edge %0d xfer_req got %b want %b", tag, n, bus.xfer_req, e_req);
      end
      checks++;
      if (bus.src_done !== e_done) begin
        failures++;
        $display("FAIL %s edge %0d src_done got %b want %b", tag, n, bus.src_done, e_done);
      end
      checks++;
      if (bus.src_ready !== e_rdy) begin
        failures++;
        $display("FAIL %s edge %0d src_ready got %b want %b", tag, n, bus.src_ready, e_rdy);
      end
      checks++;
      if (bus.xfer_data !== w) begin
        failures++;
        $display("FAIL %s edge %0d xfer_data got %h want %h", tag, n, bus.xfer_data, w);
      end
      checks++;
      if (bus.timeout_err !== 1'b0) begin
        failures++;
        $display("FAIL %s edge %0d timeout_err got %b want 0", tag, n, bus.timeout_err);
      end
      if (n == d1) bus.xfer_ack_async = 1'b1;
      if (n == f_e + d2) bus.xfer_ack_async = 1'b0;
      if (n < d_e) begin
        bus.src_valid = hold_v;
        bus.src_data  = hold_d;
      end else if (!chain) begin
        bus.src_valid = 1'b0;
      end
    end
    if (!chain) begin
      tick();
      checks++;
      if (bus.xfer_req !== 1'b0 || bus.src_ready !== 1'b1 || bus.src_done !== 1'b0) begin
        failures++;
        $display("FAIL %s idle req/ready/done got %b%b%b want 010", tag,
                 bus.xfer_req, bus.src_ready, bus.src_done);
      end
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (bus.xfer_req !== 1'b0) begin failures++; $display("FAIL reset xfer_req got %b want 0", bus.xfer_req); end
    checks++;
    if (bus.xfer_data !== '0) begin failures++; $display("FAIL reset xfer_data got %h want 00", bus.xfer_data); end
    checks++;
    if (bus.src_done !== 1'b0) begin failures++; $display("FAIL reset src_done got %b want 0", bus.src_done); end
    checks++;
    if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL reset timeout_err got %b want 0", bus.timeout_err); end
    checks++;
    if (bus.src_ready !== 1'b0) begin failures++; $display("FAIL reset src_ready got %b want 0", bus.src_ready); end
    rst = 1'b0;
    for (int n = 1; n <= SYNC + 1; n++) begin
      tick();
      checks++;
      if (bus.src_ready !== (n >= SYNC)) begin
        failures++;
        $display("FAIL reset_release edge %0d src_ready got %b want %b", n, bus.src_ready, (n >= SYNC));
      end
    end
  endtask

  task automatic test_basic();
    bus.src_valid = 1'b1;
    bus.src_data  = 8'hA5;
    exp_q.push_back(8'hA5);
    run_transfer("basic", 2, 2, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_busy();
    bus.src_valid = 1'b1;
    bus.src_data  = 8'hA5;
    exp_q.push_back(8'hA5);
    run_transfer("busy", 1, 3, 1'b1, 8'h3C, 1'b0);
  endtask

  task automatic test_back_to_back();
    bus.src_valid = 1'b1;
    bus.src_data  = 8'h01;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    run_transfer("b2b_first", 3, 3, 1'b1, 8'h02, 1'b1);
    run_transfer("b2b_second", 3, 3, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    logic [DW-1:0] cur, nxt;
    logic chain;
    cur = DW'($urandom);
    bus.src_valid = 1'b1;
    bus.src_data  = cur;
    exp_q.push_back(cur);
    for (int i = 0; i < 8; i++) begin
      nxt   = DW'($urandom);
      chain = (i < 7) && ($urandom_range(0, 1) == 1);
      if (chain) begin
        exp_q.push_back(nxt);
        run_transfer("random_chain", $urandom_range(0, 4), $urandom_range(0, 4), 1'b1, nxt, 1'b1);
      end else begin
        run_transfer("random", $urandom_range(0, 4), $urandom_range(0, 4),
                     1'($urandom_range(0, 1)), DW'($urandom), 1'b0);
        if (i < 7) begin
          bus.src_valid = 1'b1;
          bus.src_data  = nxt;
          exp_q.push_back(nxt);
        end
      end
    end
  endtask

  task automatic test_stale();
    logic [DW-1:0] w;
    int k;
    w = DW'($urandom);
    k = $urandom_range(2, 6);
    apply_reset(1'b1);
    bus.src_valid = 1'b1;
    bus.src_data  = w;
    exp_q.push_back(w);
    for (int n = 1; n <= k + SYNC; n++) begin
      tick();
      checks++;
      if (bus.src_ready !== (n == k + SYNC)) begin
        failures++;
        $display("FAIL stale edge %0d src_ready got %b want %b", n, bus.src_ready, (n == k + SYNC));
      end
      checks++;
      if (bus.xfer_req !== 1'b0) begin
        failures++;
        $display("FAIL stale edge %0d xfer_req got %b want 0", n, bus.xfer_req);
      end
      if (n == k) bus.xfer_ack_async = 1'b0;
    end
    run_transfer("stale_launch", $urandom_range(0, 4), $urandom_range(0, 4), 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_timeout();
    logic [DW-1:0] w;
    logic e_err;
    w = DW'($urandom);
    bus.src_valid = 1'b1;
    bus.src_data  = w;
    tick();
    bus.src_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      e_err = (n >= TO) && (n < TO + 4);
      checks++;
      if (bus.timeout_err !== e_err) begin
        failures++;
        $display("FAIL timeout edge %0d timeout_err got %b want %b", n, bus.timeout_err, e_err);
      end
      checks++;
      if (bus.xfer_req !== 1'b1 || bus.xfer_data !== w) begin
        failures++;
        $display("FAIL timeout edge %0d req/data got %b/%h want 1/%h", n, bus.xfer_req, bus.xfer_data, w);
      end
      if (n == TO - 2) bus.err_clear = 1'b1;
      if (n == TO)     bus.err_clear = 1'b0;
      if (n == TO + 3) bus.err_clear = 1'b1;
      if (n == TO + 4) bus.err_clear = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w;
    w = DW'($urandom) | 8'h01;
    apply_reset(1'b0);
    for (int n = 0; n < SYNC; n++) tick();
    bus.src_valid = 1'b1;
    bus.src_data  = w;
    for (int n = 0; n <= TO + 1; n++) begin
      tick();
      bus.src_valid = 1'b0;
    end
    checks++;
    if (bus.timeout_err !== 1'b1 || bus.xfer_req !== 1'b1 || bus.xfer_data !== w) begin
      failures++;
      $display("FAIL reset_mid_pre err/req/data got %b/%b/%h want 1/1/%h",
               bus.timeout_err, bus.xfer_req, bus.xfer_data, w);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.xfer_req !== 1'b0) begin failures++; $display("FAIL reset_mid xfer_req got %b want 0", bus.xfer_req); end
    checks++;
    if (bus.xfer_data !== '0) begin failures++; $display("FAIL reset_mid xfer_data got %h want 00", bus.xfer_data); end
    checks++;
    if (bus.src_done !== 1'b0) begin failures++; $display("FAIL reset_mid src_done got %b want 0", bus.src_done); end
    checks++;
    if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL reset_mid timeout_err got %b want 0", bus.timeout_err); end
    tick();
    rst = 1'b0;
    for (int n = 1; n <= SYNC; n++) begin
      tick();
      checks++;
      if (bus.src_ready !== (n >= SYNC) || bus.xfer_req !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_release edge %0d ready/req got %b/%b want %b/0",
                 n, bus.src_ready, bus.xfer_req, (n >= SYNC));
      end
    end
    w = DW'($urandom);
    bus.src_valid = 1'b1;
    bus.src_data  = w;
    exp_q.push_back(w);
    run_transfer("after_reset_mid", $urandom_range(0, 4), $urandom_range(0, 4), 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    bus.src_valid      = 1'b0;
    bus.src_data       = '0;
    bus.xfer_ack_async = 1'b0;
    bus.err_clear      = 1'b0;
    test_reset();
    test_basic();
    test_busy();
    test_back_to_back();
    test_random();
    test_stale();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
